// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and default sizing for the sequential N-operand reduction adder.
package adder_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_ADDER_WIDTH = 7;
  localparam int DEF_LEVELS      = 3;

endpackage

// File: rtl/adder_seq_ctrl_adder_share_unit.sv
// Shared two-input adder, a+b with one extra carry bit.
// Purely combinational, zero latency; there is no handshake to stall.
module adder_share_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sums 2**LEVELS operands serially through one shared adder.
// Result is valid the cycle after the last accept; in_ready drops while the result waits on out_ready.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
  parameter int LEVELS      = DEF_LEVELS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDER_WIDTH-1:0]        in_data,
  input  logic                          abort,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDER_WIDTH+LEVELS-1:0] out_sum,
  output logic                          busy,
  output logic [LEVELS:0]               op_count
);

  localparam int SUM_W = ADDER_WIDTH + LEVELS;
  localparam int CNT_W = LEVELS + 1;
  localparam logic [CNT_W-1:0] N_OPS = CNT_W'(1 << LEVELS);

  state_t           state, state_nxt;
  logic [SUM_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [SUM_W:0]   add_sum;
  logic             accept;

  // acc is zero in IDLE, so the same adder path also loads the first operand.
  adder_share_unit #(
    .WIDTH (SUM_W)
  ) u_add (
    .a   (acc),
    .b   ({{LEVELS{1'b0}}, in_data}),
    .sum (add_sum)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    in_ready  = (state != DONE);
    accept    = in_valid && in_ready;
    cnt_inc   = cnt + CNT_W'(1);

    unique case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          // The carry cannot set for legal sizing; saturating just keeps it observed.
          acc_nxt   = add_sum[SUM_W] ? '1 : add_sum[SUM_W-1:0];
          cnt_nxt   = cnt_inc;
          state_nxt = (cnt_inc == N_OPS) ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase

    // Abort wins over any accept or result handshake on the same edge.
    if (abort) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign out_valid = (state == DONE);
  assign out_sum   = out_valid ? acc : '0;
  assign busy      = (state != IDLE);
  assign op_count  = cnt;

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ADDER_WIDTH, default 7, operand width in bits.
REQ-002 The block SHALL have parameter LEVELS, default 3, reduction depth; legal values 1..4; operand count N = 2**LEVELS.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  operand offered.
REQ-006 The block SHALL have port in_ready  output  1  operand accepted this cycle when in_valid also high.
REQ-007 The block SHALL have port in_data  input  ADDER_WIDTH  unsigned operand.
REQ-008 The block SHALL have port abort  input  1  synchronous discard of the current reduction.
REQ-009 The block SHALL have port out_valid  output  1  result available.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port out_sum  output  ADDER_WIDTH+LEVELS  unsigned sum of N operands.
REQ-012 The block SHALL have port busy  output  1  high in ACCUM or DONE.
REQ-013 The block SHALL have port op_count  output  LEVELS+1  operands accepted in the current reduction.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-015 The block SHALL define an accept as in_valid and in_ready both high on a clk edge.
REQ-016 In IDLE: in_ready=1, acc=0, op_count=0; on accept: acc<=in_data (zero-extended), op_count<=1, next state ACCUM; if N=1, next state DONE instead.
REQ-017 In ACCUM: in_ready=1; on accept: acc<=acc+in_data, op_count<=op_count+1; the accept making op_count reach N moves the FSM to DONE.
REQ-018 In ACCUM without in_valid: acc, op_count and state SHALL hold; gaps of any length are legal.
REQ-019 In DONE: in_ready=0, out_valid=1, out_sum=acc, held stable until out_ready=1.
REQ-020 On the out_valid and out_ready edge in DONE: the FSM SHALL return to IDLE, clear acc and op_count, and drop out_valid next cycle.
REQ-021 Latency: out_valid SHALL rise the cycle after the Nth accept; max throughput is one reduction per N+1 cycles.
REQ-022 The accumulator SHALL be ADDER_WIDTH+LEVELS bits and never overflow, since N*(2**ADDER_WIDTH-1) fits.
REQ-023 Each addition SHALL be performed by one shared two-input adder instance; one addition per cycle.
REQ-024 abort high on an edge SHALL force IDLE with acc=0, op_count=0, out_valid=0, and SHALL take priority over a simultaneous accept or output handshake.
REQ-025 out_valid SHALL never be high outside DONE, and in_ready SHALL never be high in DONE.
REQ-026 out_sum SHALL read 0 whenever out_valid=0.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, acc=0, op_count=0, out_valid=0, out_sum=0, busy=0; in_ready=1 combinationally in IDLE.
REQ-028 Reset asserted mid-ACCUM or in DONE SHALL discard partial or pending results, with no out_valid after release.
REQ-029 After rst_n deasserts, the first accept SHALL be possible on the first clk edge.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, ACCUM, DONE) and the default ADDER_WIDTH/LEVELS constants.
REQ-031 One sub-module, adder_share_unit, SHALL be used: parameterised width, combinational a+b with one extra carry bit, instantiated once.
REQ-032 All state SHALL be in one clk/rst_n process; next-state and handshake logic SHALL be combinational.

Verification
REQ-033 Defaults: 8 consecutive accepts of 127 -> out_valid one cycle after 8th accept, out_sum=1016, op_count=8.
REQ-034 LEVELS=2: operands 1,2,3,4 with 2-cycle in_valid gaps -> out_sum=10; in_ready high throughout; no early out_valid.
REQ-035 Back-to-back: out_ready low 5 cycles in DONE -> out_sum stable, in_ready=0; then out_ready=1 -> IDLE next cycle, next reduction of 8 x 1 gives 8.
REQ-036 rst_n pulsed low after 5 accepts -> outputs at reset values immediately; next 8 x 2 -> out_sum=16.
REQ-037 abort together with the 8th accept -> no out_valid, IDLE, op_count=0; abort together with the DONE handshake -> IDLE, no duplicate result.
